// File: rtl/trx_pkg.sv
// Shared types for the nibble receive path: packer FSM encoding and the
// default width of the statistics counters.
package trx_pkg;

  typedef enum logic {
    ST_LO = 1'b0,
    ST_HI = 1'b1
  } pk_state_e;

  localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/rx_nibble_packer_if.sv
// Nibble stream from the receiver plus the packed byte stream to the consumer.
// The slave side is the packer; the master side is the surrounding environment.
interface rx_nibble_packer_if;
    logic       nib_valid;
    logic [3:0] nib_data;
    logic       nib_err_corr;
    logic       nib_err_uncorr;
    logic       rx_not_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_corr;
    logic       out_ready;

    modport master (
        output nib_valid, nib_data, nib_err_corr, nib_err_uncorr, out_ready,
        input  rx_not_ready, out_valid, out_data, out_corr
    );

    modport slave (
        input  nib_valid, nib_data, nib_err_corr, nib_err_uncorr, out_ready,
        output rx_not_ready, out_valid, out_data, out_corr
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; a write while full is taken only when a pop
// frees the head slot in the same cycle.
module sync_fifo_fwft #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // Pointers carry one extra lap bit: equal means empty, lap bits differing
    // with equal indices means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en = push && (!full || pop) && !flush;
    assign rd_en = pop && !empty && !flush;
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage has no reset; empty masks stale contents on rdata.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/rx_nibble_packer.sv
// Packs low/high nibble pairs into bytes, drops bytes with uncorrectable
// nibbles, and queues good bytes with a corrected-nibble flag.
module rx_nibble_packer
    import trx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    rx_nibble_packer_if.slave   bus,
    output logic [CNT_W-1:0]    corr_cnt,
    output logic [CNT_W-1:0]    drop_cnt,
    output logic [CNT_W-1:0]    ovf_cnt,
    output logic                ovf_sticky
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pk_state_e  state_q, state_d;
    logic [3:0] lo_q, lo_d;
    logic       lo_corr_q, lo_corr_d;
    logic       lo_bad_q, lo_bad_d;
    logic       nib_corr;
    logic       push;
    logic       corr_inc;
    logic       drop_inc;
    logic       ovf_inc;
    logic       pop;
    logic       fifo_empty;
    logic       fifo_full;
    logic [8:0] fifo_rdata;
    logic [8:0] push_data;

    // An uncorrectable flag overrides a simultaneous corrected flag.
    assign nib_corr  = bus.nib_err_corr && !bus.nib_err_uncorr;
    assign push_data = {lo_corr_q || nib_corr, bus.nib_data, lo_q};

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        lo_corr_d = lo_corr_q;
        lo_bad_d  = lo_bad_q;
        push      = 1'b0;
        corr_inc  = 1'b0;
        drop_inc  = 1'b0;
        if (bus.nib_valid && !flush) begin
            corr_inc = nib_corr;
            case (state_q)
                ST_LO: begin
                    state_d   = ST_HI;
                    lo_d      = bus.nib_data;
                    lo_corr_d = nib_corr;
                    lo_bad_d  = bus.nib_err_uncorr;
                end
                ST_HI: begin
                    state_d = ST_LO;
                    if (lo_bad_q || bus.nib_err_uncorr) drop_inc = 1'b1;
                    else                                push     = 1'b1;
                end
            endcase
        end
        if (flush) state_d = ST_LO;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_LO;
            lo_q      <= '0;
            lo_corr_q <= 1'b0;
            lo_bad_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            lo_corr_q <= lo_corr_d;
            lo_bad_q  <= lo_bad_d;
        end
    end

    assign pop     = !fifo_empty && bus.out_ready;
    assign ovf_inc = push && fifo_full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt   <= '0;
            drop_cnt   <= '0;
            ovf_cnt    <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (corr_inc && corr_cnt != '1) corr_cnt <= corr_cnt + CNT_ONE;
            if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_ONE;
            if (ovf_inc  && ovf_cnt  != '1) ovf_cnt  <= ovf_cnt + CNT_ONE;
            if (flush)        ovf_sticky <= 1'b0;
            else if (ovf_inc) ovf_sticky <= 1'b1;
        end
    end

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign bus.out_valid    = !fifo_empty;
    assign bus.out_data     = fifo_rdata[7:0];
    assign bus.out_corr     = fifo_rdata[8];
    assign bus.rx_not_ready = fifo_full;
endmodule

// File: tb/tb_rx_nibble_packer.sv
// Randomized and directed bench for rx_nibble_packer against a queue-based
// reference model of the packing, drop, overflow and flush rules.
module tb_rx_nibble_packer;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          flush;
    logic [CW-1:0] corr_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] ovf_cnt;
    logic          ovf_sticky;

    rx_nibble_packer_if bus ();

    rx_nibble_packer #(
        .DEPTH (DEPTH),
        .CNT_W (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus.slave),
        .corr_cnt   (corr_cnt),
        .drop_cnt   (drop_cnt),
        .ovf_cnt    (ovf_cnt),
        .ovf_sticky (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus an optional half-byte.
    logic [8:0] mq[$];
    bit         m_have_lo;
    logic [3:0] m_lo;
    bit         m_lo_c;
    bit         m_lo_bad;
    int         m_corr, m_drop, m_ovf;
    bit         m_sticky;

    function automatic int sat(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_have_lo = 0; m_lo = '0; m_lo_c = 0; m_lo_bad = 0;
        m_corr = 0; m_drop = 0; m_ovf = 0; m_sticky = 0;
    endtask

    task automatic model_step(input bit v, input logic [3:0] d, input bit c, input bit u,
                              input bit f, input bit r);
        int         sz;
        bit         do_pop;
        bit         do_push;
        bit         cf;
        logic [8:0] nb;
        sz      = mq.size();
        do_pop  = (sz > 0) && r;
        do_push = 0;
        nb      = '0;
        if (f) begin
            mq.delete();
            m_have_lo = 0;
            m_sticky  = 0;
            return;
        end
        if (v) begin
            cf = c && !u;
            if (cf) m_corr = sat(m_corr);
            if (!m_have_lo) begin
                m_have_lo = 1; m_lo = d; m_lo_c = cf; m_lo_bad = u;
            end else begin
                m_have_lo = 0;
                if (m_lo_bad || u) m_drop = sat(m_drop);
                else begin
                    do_push = 1;
                    nb = {m_lo_c || cf, d, m_lo};
                end
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            if (sz == DEPTH && !do_pop) begin
                m_ovf = sat(m_ovf);
                m_sticky = 1;
            end else mq.push_back(nb);
        end
    endtask

    task automatic check_all(input string tag);
        bit         ev;
        logic [8:0] head;
        ev   = mq.size() > 0;
        head = ev ? mq[0] : 9'h0;
        check({tag, ".valid"},  bus.out_valid, ev);
        check({tag, ".data"},   bus.out_data, head[7:0]);
        check({tag, ".corr"},   bus.out_corr, head[8]);
        check({tag, ".nrdy"},   bus.rx_not_ready, mq.size() == DEPTH);
        check({tag, ".ccnt"},   corr_cnt, m_corr);
        check({tag, ".dcnt"},   drop_cnt, m_drop);
        check({tag, ".ocnt"},   ovf_cnt, m_ovf);
        check({tag, ".sticky"}, ovf_sticky, m_sticky);
    endtask

    task automatic cycle(input string tag, input bit v, input logic [3:0] d, input bit c,
                         input bit u, input bit f, input bit r);
        @(negedge clk);
        bus.nib_valid = v; bus.nib_data = d; bus.nib_err_corr = c;
        bus.nib_err_uncorr = u; flush = f; bus.out_ready = r;
        @(posedge clk);
        model_step(v, d, c, u, f, r);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        bus.nib_valid = 0; bus.nib_data = 0; bus.nib_err_corr = 0;
        bus.nib_err_uncorr = 0; flush = 0; bus.out_ready = 0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] exp_bytes [5];
        rst = 1'b1; flush = 0;
        bus.nib_valid = 0; bus.nib_data = 0; bus.nib_err_corr = 0;
        bus.nib_err_uncorr = 0; bus.out_ready = 0;
        model_reset();
        #1;
        check_all("reset_async");
        do_reset("reset");

        // Clean pair 4,A.
        cycle("r040a", 1, 4'h4, 0, 0, 0, 1);
        cycle("r040b", 1, 4'hA, 0, 0, 0, 1);
        check("r040.data", bus.out_data, 8'hA4);
        check("r040.corr", bus.out_corr, 1'b0);
        cycle("r040c", 0, 4'h0, 0, 0, 0, 1);

        // Corrected low nibble.
        do_reset("r041rst");
        cycle("r041a", 1, 4'h4, 1, 0, 0, 1);
        cycle("r041b", 1, 4'hA, 0, 0, 0, 1);
        check("r041.data", bus.out_data, 8'hA4);
        check("r041.corr", bus.out_corr, 1'b1);
        check("r041.ccnt", corr_cnt, 1);

        // Uncorrectable high nibble drops the byte; next pair is clean.
        do_reset("r042rst");
        cycle("r042a", 1, 4'h4, 0, 0, 0, 1);
        cycle("r042b", 1, 4'hA, 0, 1, 0, 1);
        check("r042.valid", bus.out_valid, 1'b0);
        check("r042.dcnt", drop_cnt, 1);
        cycle("r042c", 1, 4'h3, 0, 0, 0, 1);
        cycle("r042d", 1, 4'h5, 0, 0, 0, 1);
        check("r042.data", bus.out_data, 8'h53);

        // Five bytes with the consumer stalled: one overflow, first four kept.
        do_reset("r043rst");
        for (int i = 0; i < 5; i++) begin
            exp_bytes[i] = 8'((i + 1) * 16 + i);
            cycle("r043lo", 1, exp_bytes[i][3:0], 0, 0, 0, 0);
            cycle("r043hi", 1, exp_bytes[i][7:4], 0, 0, 0, 0);
            if (i == 3) check("r043.full", bus.rx_not_ready, 1'b1);
        end
        check("r043.ocnt", ovf_cnt, 1);
        check("r043.sticky", ovf_sticky, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("r043.drain", bus.out_data, exp_bytes[i]);
            cycle("r043pop", 0, 4'h0, 0, 0, 0, 1);
        end
        check("r043.empty", bus.out_valid, 1'b0);

        // Push while full coinciding with a pop.
        do_reset("r044rst");
        for (int i = 0; i < 4; i++) begin
            cycle("r044lo", 1, exp_bytes[i][3:0], 0, 0, 0, 0);
            cycle("r044hi", 1, exp_bytes[i][7:4], 0, 0, 0, 0);
        end
        cycle("r044lo", 1, 4'hE, 0, 0, 0, 0);
        cycle("r044hi", 1, 4'h7, 0, 0, 0, 1);
        check("r044.ocnt", ovf_cnt, 0);
        check("r044.full", bus.rx_not_ready, 1'b1);
        for (int i = 1; i < 4; i++) begin
            check("r044.drain", bus.out_data, exp_bytes[i]);
            cycle("r044pop", 0, 4'h0, 0, 0, 0, 1);
        end
        check("r044.last", bus.out_data, 8'h7E);
        cycle("r044pop", 0, 4'h0, 0, 0, 0, 1);

        // Asynchronous reset pulse mid-byte.
        do_reset("r045rst");
        cycle("r045a", 1, 4'h9, 1, 0, 0, 0);
        @(negedge clk);
        bus.nib_valid = 0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("r045async");
        #1 rst = 1'b0;
        cycle("r045b", 1, 4'h1, 0, 0, 0, 1);
        cycle("r045c", 1, 4'h2, 0, 0, 0, 1);
        check("r045.data", bus.out_data, 8'h21);

        // Flush with a same-cycle nibble and pop; counters persist.
        do_reset("flushrst");
        cycle("fl1", 1, 4'h1, 1, 0, 0, 0);
        cycle("fl2", 1, 4'h2, 0, 0, 0, 0);
        cycle("fl3", 1, 4'h3, 0, 0, 0, 0);
        cycle("fl4", 1, 4'h4, 1, 0, 1, 1);
        check("flush.valid", bus.out_valid, 1'b0);
        check("flush.ccnt", corr_cnt, 1);
        cycle("fl5", 1, 4'h6, 0, 0, 0, 1);
        cycle("fl6", 1, 4'h8, 0, 0, 0, 1);
        check("flush.data", bus.out_data, 8'h86);

        // Random traffic; small CNT_W drives the counters into saturation.
        do_reset("randrst");
        for (int n = 0; n < 3000; n++) begin
            cycle("rand",
                  $urandom_range(99) < 60,
                  4'($urandom_range(15)),
                  $urandom_range(99) < 25,
                  $urandom_range(99) < 20,
                  $urandom_range(99) < 2,
                  $urandom_range(99) < 45);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rx_nibble_packer.md
RX_NIBBLE_PACKER -- requirements
Module: rx_nibble_packer

Interface
REQ-001 Parameter DEPTH, default 4, byte FIFO depth; power of two, 2..16.
REQ-002 Parameter CNT_W, default 8, width of each saturating statistics counter.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 nib_valid  in  1  one-cycle strobe from the receiver: a decoded nibble is present.
REQ-006 nib_data  in  4  decoded (corrected) nibble from the receiver.
REQ-007 nib_err_corr  in  1  qualifies nib_valid: single-bit error was corrected.
REQ-008 nib_err_uncorr  in  1  qualifies nib_valid: nibble is uncorrectable.
REQ-009 flush  in  1  discard any held half-byte and empty the FIFO.
REQ-010 rx_not_ready  out  1  back-pressure to the receiver: FIFO full.
REQ-011 out_valid  out  1  FIFO head byte available.
REQ-012 out_data  out  8  FIFO head byte.
REQ-013 out_corr  out  1  head byte contained at least one corrected nibble.
REQ-014 out_ready  in  1  consumer accepts the head byte when out_valid is high.
REQ-015 corr_cnt  out  CNT_W  saturating count of corrected nibbles accepted.
REQ-016 drop_cnt  out  CNT_W  saturating count of bytes dropped for an uncorrectable nibble.
REQ-017 ovf_cnt  out  CNT_W  saturating count of bytes lost to a full FIFO.
REQ-018 ovf_sticky  out  1  set on any overflow; cleared only by reset or flush.

Function
REQ-019 The packer SHALL run a two-state FSM: LO (waiting for the low nibble) and HI (low nibble held).
REQ-020 In LO, nib_valid SHALL latch nib_data as the low nibble, record the nibble error flags, and move to HI.
REQ-021 In HI, nib_valid SHALL form the byte {nib_data, held_lo}, push it with out_corr equal to the OR of both nibbles' corr flags, and return to LO.
REQ-022 A nibble with nib_err_uncorr in LO SHALL still advance the FSM to HI, with the pending byte marked bad.
REQ-023 A byte marked bad, or completed by a nibble with nib_err_uncorr, SHALL NOT be pushed; drop_cnt SHALL increment once per such byte.
REQ-024 corr_cnt SHALL increment for every accepted nib_valid with nib_err_corr=1 and nib_err_uncorr=0.
REQ-025 If both err flags are high, the nibble SHALL be treated as uncorrectable only.
REQ-026 Push-to-out_valid latency SHALL be one cycle: the byte is visible the cycle after the completing nib_valid.
REQ-027 The FIFO SHALL be first-word-fall-through; a pop occurs when out_valid and out_ready are both high.
REQ-028 Simultaneous push and pop SHALL be allowed at any fill level, including full, with the occupancy unchanged.
REQ-029 rx_not_ready SHALL equal (occupancy == DEPTH), registered, with no combinational path from out_ready.
REQ-030 A push while full without a simultaneous pop SHALL discard the byte, increment ovf_cnt, and set ovf_sticky; FIFO contents SHALL be unchanged.
REQ-031 Read and write pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full and empty SHALL be derived from the MSB and the remaining bits.
REQ-032 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-033 flush SHALL take priority over a same-cycle nib_valid or pop: the FSM goes to LO, the FIFO empties, and ovf_sticky clears; the statistics counters SHALL retain their values.
REQ-034 nib_data SHALL be ignored while nib_valid is low.

Reset
REQ-035 On rst, the FSM SHALL enter LO, both pointers go to 0, and out_valid=0, rx_not_ready=0, out_data=0, out_corr=0, all counters=0, and ovf_sticky=0.
REQ-036 Reset asserted mid-byte or mid-transfer SHALL discard all held data with no partial output after release.
REQ-037 The first nib_valid after reset deassertion SHALL be treated as a low nibble.

Structure
REQ-038 The FSM state encoding and the default CNT_W value SHALL live in a shared package, trx_pkg.
REQ-039 The FIFO SHALL be a separate sub-module, sync_fifo_fwft (parameters DEPTH and WIDTH=9), carrying {corr, byte}.

Verification
REQ-040 Nibbles 4, then A, clean, with out_ready=1: out_data=0xA4 and out_corr=0 one cycle after the second nib_valid.
REQ-041 Nibble 4 with nib_err_corr, then A clean: out_data=0xA4, out_corr=1, corr_cnt=1.
REQ-042 Nibble 4 clean, then A with nib_err_uncorr: no out_valid, drop_cnt=1, FSM in LO; the next pair 3,5 yields 0x53.
REQ-043 out_ready=0 while 5 bytes are sent with DEPTH=4: rx_not_ready=1 after the 4th byte, ovf_cnt=1, ovf_sticky=1; draining returns the first 4 bytes in order.
REQ-044 FIFO full, and a push coincides with out_ready=1: ovf_cnt unchanged, occupancy stays 4, order preserved.
REQ-045 A single low nibble, then rst pulsed asynchronously between edges: all outputs 0; the next nibbles 1,2 yield 0x21.
